// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB and drives datapath strobes per state.
// Latency FETCH->FETCH (no waits): BEQ 3, R/ADDI/SS 4, LS 5, MUL 3+MUL_CYCLES; each wait cycle adds 1.
// Backpressure: holds in FETCH until i_instr_ready, holds in MEM (strobes stable) until i_mem_ready.
//
// Ports:
//   i_clk, i_reset            rising-edge clock, synchronous active-high reset
//   i_opcode, i_funct         instruction fields, sampled and latched in DECODE
//   i_instr_ready             instruction memory has data for o_instr_req
//   i_mem_ready               data memory completes the current read/write
//   o_instr_req, o_ir_write, o_pc_write        fetch controls
//   o_reg_dst, o_branch, o_mem_read, o_mem_to_reg, o_mem_write, o_alu_src, o_reg_write  datapath strobes
//   o_alu_op                  00 add, 01 sub/compare, 10 R-format, 11 multiply
//   o_illegal_op              one-cycle pulse in DECODE on an undecodable opcode
//   o_busy                    high in every state except FETCH
module multicycle_control_unit #(
    parameter int                  OPCODE_W   = 4,
    parameter int                  FUNCT_W    = 2,
    parameter logic [FUNCT_W-1:0]  MUL_FUNCT  = 2'b11,
    parameter int                  MUL_CYCLES = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [OPCODE_W-1:0] i_opcode,
    input  logic [FUNCT_W-1:0]  i_funct,
    input  logic                i_instr_ready,
    input  logic                i_mem_ready,
    output logic                o_instr_req,
    output logic                o_ir_write,
    output logic                o_pc_write,
    output logic                o_reg_dst,
    output logic                o_branch,
    output logic                o_mem_read,
    output logic                o_mem_to_reg,
    output logic                o_mem_write,
    output logic                o_alu_src,
    output logic                o_reg_write,
    output logic [1:0]          o_alu_op,
    output logic                o_illegal_op,
    output logic                o_busy
);

    localparam int CNT_W = $clog2(MUL_CYCLES + 1);

    localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(4'b0110);
    localparam logic [OPCODE_W-1:0] OP_LS   = OPCODE_W'(4'b0010);
    localparam logic [OPCODE_W-1:0] OP_SS   = OPCODE_W'(4'b0011);
    localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(4'b0100);
    localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(4'b0001);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [OPCODE_W-1:0]  r_op;
    logic [FUNCT_W-1:0]   r_funct;
    logic [CNT_W-1:0]     r_mul_cnt;

    // Classes of the latched instruction (valid from EXEC onward)
    logic w_is_r, w_is_ls, w_is_ss, w_is_beq, w_is_addi, w_is_mul;
    // Legality/MUL of the incoming instruction (used only in DECODE, before latching)
    logic w_dec_legal, w_dec_mul;

    assign w_is_r    = (r_op == OP_R);
    assign w_is_ls   = (r_op == OP_LS);
    assign w_is_ss   = (r_op == OP_SS);
    assign w_is_beq  = (r_op == OP_BEQ);
    assign w_is_addi = (r_op == OP_ADDI);
    assign w_is_mul  = w_is_r && (r_funct == MUL_FUNCT);

    assign w_dec_legal = (i_opcode == OP_R)  || (i_opcode == OP_LS)  || (i_opcode == OP_SS) ||
                         (i_opcode == OP_BEQ) || (i_opcode == OP_ADDI);
    assign w_dec_mul   = (i_opcode == OP_R) && (i_funct == MUL_FUNCT);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_FETCH;
            r_op      <= '0;
            r_funct   <= '0;
            r_mul_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_op    <= i_opcode;
                r_funct <= i_funct;
                // Counter holds the EXEC cycles still to go after the current one
                if (w_dec_mul) begin
                    r_mul_cnt <= CNT_W'(MUL_CYCLES - 1);
                end
            end else if (r_state == S_EXEC && r_mul_cnt != '0) begin
                r_mul_cnt <= r_mul_cnt - CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        o_instr_req  = 1'b0;
        o_ir_write   = 1'b0;
        o_pc_write   = 1'b0;
        o_reg_dst    = 1'b0;
        o_branch     = 1'b0;
        o_mem_read   = 1'b0;
        o_mem_to_reg = 1'b0;
        o_mem_write  = 1'b0;
        o_alu_src    = 1'b0;
        o_reg_write  = 1'b0;
        o_alu_op     = 2'b00;
        o_illegal_op = 1'b0;
        o_busy       = 1'b0;

        // Reset is synchronous, so the state may still be mid-instruction during the
        // reset cycle; masking here keeps every strobe low while reset is asserted.
        if (!i_reset) begin
            case (r_state)
                S_FETCH: begin
                    o_instr_req = 1'b1;
                    if (i_instr_ready) begin
                        o_ir_write = 1'b1;
                        o_pc_write = 1'b1;
                        w_next     = S_DECODE;
                    end
                end
                S_DECODE: begin
                    o_busy = 1'b1;
                    if (w_dec_legal) begin
                        w_next = S_EXEC;
                    end else begin
                        o_illegal_op = 1'b1;
                        w_next       = S_FETCH;
                    end
                end
                S_EXEC: begin
                    o_busy    = 1'b1;
                    o_alu_src = w_is_ls || w_is_ss || w_is_addi;
                    if (w_is_mul) begin
                        o_alu_op = 2'b11;
                    end else if (w_is_r) begin
                        o_alu_op = 2'b10;
                    end else if (w_is_beq) begin
                        o_alu_op = 2'b01;
                    end
                    if (w_is_mul) begin
                        if (r_mul_cnt == '0) begin
                            w_next = S_WB;
                        end
                    end else if (w_is_beq) begin
                        o_branch = 1'b1;
                        w_next   = S_FETCH;
                    end else if (w_is_r || w_is_addi) begin
                        w_next = S_WB;
                    end else if (w_is_ls || w_is_ss) begin
                        w_next = S_MEM;
                    end else begin
                        w_next = S_FETCH;
                    end
                end
                S_MEM: begin
                    o_busy      = 1'b1;
                    o_alu_src   = 1'b1;
                    o_mem_read  = w_is_ls;
                    o_mem_write = w_is_ss;
                    if (i_mem_ready) begin
                        w_next = w_is_ls ? S_WB : S_FETCH;
                    end
                end
                S_WB: begin
                    o_busy       = 1'b1;
                    o_reg_write  = 1'b1;
                    o_reg_dst    = w_is_r;
                    o_mem_to_reg = w_is_ls;
                    w_next       = S_FETCH;
                end
                default: begin
                    w_next = S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] opcode;
    logic [1:0] funct;
    logic       instr_ready;
    logic       mem_ready;

    logic       instr_req, ir_write, pc_write, reg_dst, branch, mem_read;
    logic       mem_to_reg, mem_write, alu_src, reg_write, illegal_op, busy;
    logic [1:0] alu_op;

    multicycle_control_unit #(
        .OPCODE_W   (4),
        .FUNCT_W    (2),
        .MUL_FUNCT  (2'b11),
        .MUL_CYCLES (4)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_opcode      (opcode),
        .i_funct       (funct),
        .i_instr_ready (instr_ready),
        .i_mem_ready   (mem_ready),
        .o_instr_req   (instr_req),
        .o_ir_write    (ir_write),
        .o_pc_write    (pc_write),
        .o_reg_dst     (reg_dst),
        .o_branch      (branch),
        .o_mem_read    (mem_read),
        .o_mem_to_reg  (mem_to_reg),
        .o_mem_write   (mem_write),
        .o_alu_src     (alu_src),
        .o_reg_write   (reg_write),
        .o_alu_op      (alu_op),
        .o_illegal_op  (illegal_op),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    // Output vector bit positions
    localparam logic [13:0] B_REQ  = 14'h2000;
    localparam logic [13:0] B_IRW  = 14'h1000;
    localparam logic [13:0] B_PCW  = 14'h0800;
    localparam logic [13:0] B_RDST = 14'h0400;
    localparam logic [13:0] B_BR   = 14'h0200;
    localparam logic [13:0] B_MRD  = 14'h0100;
    localparam logic [13:0] B_M2R  = 14'h0080;
    localparam logic [13:0] B_MWR  = 14'h0040;
    localparam logic [13:0] B_ASRC = 14'h0020;
    localparam logic [13:0] B_RWR  = 14'h0010;
    localparam logic [13:0] B_OP11 = 14'h000C;
    localparam logic [13:0] B_OP10 = 14'h0008;
    localparam logic [13:0] B_OP01 = 14'h0004;
    localparam logic [13:0] B_ILL  = 14'h0002;
    localparam logic [13:0] B_BUSY = 14'h0001;

    // Expected per-cycle output patterns
    localparam logic [13:0] E_ZERO     = 14'h0000;
    localparam logic [13:0] E_F_WAIT   = B_REQ;
    localparam logic [13:0] E_F_GO     = B_REQ | B_IRW | B_PCW;
    localparam logic [13:0] E_DEC      = B_BUSY;
    localparam logic [13:0] E_DEC_ILL  = B_BUSY | B_ILL;
    localparam logic [13:0] E_EX_R     = B_BUSY | B_OP10;
    localparam logic [13:0] E_EX_MUL   = B_BUSY | B_OP11;
    localparam logic [13:0] E_EX_BEQ   = B_BUSY | B_OP01 | B_BR;
    localparam logic [13:0] E_EX_IMM   = B_BUSY | B_ASRC;
    localparam logic [13:0] E_MEM_LS   = B_BUSY | B_ASRC | B_MRD;
    localparam logic [13:0] E_MEM_SS   = B_BUSY | B_ASRC | B_MWR;
    localparam logic [13:0] E_WB_R     = B_BUSY | B_RWR | B_RDST;
    localparam logic [13:0] E_WB_LS    = B_BUSY | B_RWR | B_M2R;
    localparam logic [13:0] E_WB_ADDI  = B_BUSY | B_RWR;

    localparam logic [3:0] XOP = 4'b1111;  // junk on the opcode bus outside DECODE
    localparam logic [1:0] XFN = 2'b11;

    logic [13:0] exp_q[$];
    int          tag_q[$];
    int          step_no = 0;
    int          checks  = 0;
    int          errors  = 0;

    wire [13:0] got = {instr_req, ir_write, pc_write, reg_dst, branch, mem_read,
                       mem_to_reg, mem_write, alu_src, reg_write, alu_op, illegal_op, busy};

    // One clock cycle of stimulus; the expected outputs for that cycle go to the scoreboard
    task automatic step(input logic rst, input logic ir, input logic mr,
                        input logic [3:0] op, input logic [1:0] fn, input logic [13:0] exp);
        @(posedge clk);
        #1;
        reset       = rst;
        instr_ready = ir;
        mem_ready   = mr;
        opcode      = op;
        funct       = fn;
        exp_q.push_back(exp);
        tag_q.push_back(step_no);
        step_no++;
    endtask

    // Monitor: samples on the falling edge, compares against the oldest expectation
    initial begin
        logic [13:0] e;
        int          t;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL cycle_%0d outputs got %04h expected %04h", t, got, e);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; instr_ready = 1'b1; mem_ready = 1'b0; opcode = XOP; funct = XFN;

        // Reset held two cycles with InstrReady high: everything low
        step(1, 1, 0, XOP, XFN, E_ZERO);
        step(1, 1, 0, XOP, XFN, E_ZERO);

        // R ADD, no waits: 4 cycles
        step(0, 1, 0, XOP,     XFN,   E_F_GO);
        step(0, 0, 0, 4'b0110, 2'b00, E_DEC);
        step(0, 0, 0, XOP,     XFN,   E_EX_R);
        step(0, 0, 0, XOP,     XFN,   E_WB_R);

        // MUL: EXEC held 4 cycles, 7 total
        step(0, 1, 0, XOP,     XFN,   E_F_GO);
        step(0, 0, 0, 4'b0110, 2'b11, E_DEC);
        step(0, 0, 0, XOP,     2'b00, E_EX_MUL);
        step(0, 0, 0, XOP,     2'b00, E_EX_MUL);
        step(0, 0, 0, XOP,     2'b00, E_EX_MUL);
        step(0, 0, 0, XOP,     2'b00, E_EX_MUL);
        step(0, 0, 0, XOP,     XFN,   E_WB_R);

        // Fetch wait with MemReady high (ignored), then LS with 3 memory wait cycles: 8 total
        step(0, 0, 1, XOP,     XFN,   E_F_WAIT);
        step(0, 1, 0, XOP,     XFN,   E_F_GO);
        step(0, 0, 0, 4'b0010, 2'b00, E_DEC);
        step(0, 1, 1, XOP,     XFN,   E_EX_IMM);
        step(0, 1, 0, XOP,     XFN,   E_MEM_LS);
        step(0, 1, 0, XOP,     XFN,   E_MEM_LS);
        step(0, 1, 0, XOP,     XFN,   E_MEM_LS);
        step(0, 1, 1, XOP,     XFN,   E_MEM_LS);
        step(0, 0, 0, XOP,     XFN,   E_WB_LS);

        // SS: MemWrite, no RegWrite, back to FETCH after MEM
        step(0, 1, 0, XOP,     XFN,   E_F_GO);
        step(0, 0, 0, 4'b0011, 2'b00, E_DEC);
        step(0, 0, 0, XOP,     XFN,   E_EX_IMM);
        step(0, 0, 1, XOP,     XFN,   E_MEM_SS);

        // BEQ: Branch for exactly one EXEC cycle, 3 total
        step(0, 1, 0, XOP,     XFN,   E_F_GO);
        step(0, 0, 0, 4'b0100, 2'b00, E_DEC);
        step(0, 0, 0, XOP,     XFN,   E_EX_BEQ);

        // ADDI: immediate ALU, writeback without RegDst/MemToReg
        step(0, 1, 0, XOP,     XFN,   E_F_GO);
        step(0, 0, 0, 4'b0001, 2'b00, E_DEC);
        step(0, 0, 0, XOP,     XFN,   E_EX_IMM);
        step(0, 0, 0, XOP,     XFN,   E_WB_ADDI);

        // Illegal opcode: one pulse in DECODE, then FETCH
        step(0, 1, 0, XOP,     XFN,   E_F_GO);
        step(0, 0, 0, 4'b1111, 2'b00, E_DEC_ILL);
        step(0, 0, 0, XOP,     XFN,   E_F_WAIT);

        // LS aborted by reset while in MEM
        step(0, 1, 0, XOP,     XFN,   E_F_GO);
        step(0, 0, 0, 4'b0010, 2'b00, E_DEC);
        step(0, 0, 0, XOP,     XFN,   E_EX_IMM);
        step(0, 0, 0, XOP,     XFN,   E_MEM_LS);
        step(1, 0, 0, XOP,     XFN,   E_ZERO);
        step(0, 0, 1, XOP,     XFN,   E_F_WAIT);
        step(0, 1, 0, XOP,     XFN,   E_F_GO);

        // Let the monitor drain the scoreboard, bounded
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
